// File: rtl/ir_sensor_sweep_if.sv
// rtl/ir_sensor_sweep_if.sv - A2D conversion handshake between the IR sweep sequencer and the SPI A2D
// Signals:
//   strt_cnv        : one-cycle conversion start          (master -> slave)
//   chnnl[2:0]      : channel of the current conversion   (master -> slave)
//   cnv_cmplt       : conversion complete, level          (slave -> master)
//   res[11:0]       : conversion result, valid while cnv_cmplt=1 (slave -> master)
// Modports: master = sweep sequencer, slave = A2D.
interface ir_sensor_sweep_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/ir_sensor_sweep.sv
// rtl/ir_sensor_sweep.sv - IR sensor sweep sequencer driving the A2D conversion handshake
// Enables the IR emitters, waits a settle time, converts channels 0..NUM_CH-1 in order
// and keeps each 12-bit result in a register bank read by the steering logic.
// Optional build macro: AMBIENT_CANCEL_EN - adds a dark (ambient) pass before the lit
// pass and stores lit minus ambient, saturated at 0.
// Ports:
//   i_clk        : system clock
//   i_rst_n      : synchronous active-low reset
//   i_go         : sweep request, sampled only in IDLE
//   o_ir_en      : IR emitter enable
//   o_busy       : high whenever not IDLE
//   o_sweep_done : one-cycle pulse when the sweep ends
//   o_a2d_err    : sticky conversion-timeout flag, cleared by the next accepted go
//   i_rd_idx     : result bank read index
//   o_rd_data    : bank[i_rd_idx], 0 when i_rd_idx >= NUM_CH
//   a2d          : A2D handshake (strt_cnv, chnnl, cnv_cmplt, res)
module ir_sensor_sweep #(
  parameter int NUM_CH         = 8,
  parameter int SETTLE_CYCLES  = 4096,
  parameter int TIMEOUT_CYCLES = 2047
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_go,
  output logic              o_ir_en,
  output logic              o_busy,
  output logic              o_sweep_done,
  output logic              o_a2d_err,
  input  logic [2:0]        i_rd_idx,
  output logic [11:0]       o_rd_data,
  ir_sensor_sweep_if.master a2d
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (SW > TW) ? SW : TW;
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_ch;
  logic          r_err;
  logic [11:0]   r_bank [NUM_CH];

  logic          w_lit;
  logic          w_clr;
  logic          w_load_settle;
  logic          w_load_to;
  logic          w_store;
  logic          w_inc;
  logic          w_err_set;
  logic [11:0]   w_wr_data;

`ifdef AMBIENT_CANCEL_EN
  logic          r_lit;
  logic [11:0]   r_amb [NUM_CH];
  logic [11:0]   w_amb_cur;
  logic          w_to_lit;
  assign w_lit = r_lit;
`else
  assign w_lit = 1'b1;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and datapath strobes
  always_comb begin
    w_next        = r_state;
    w_clr         = 1'b0;
    w_load_settle = 1'b0;
    w_load_to     = 1'b0;
    w_store       = 1'b0;
    w_inc         = 1'b0;
    w_err_set     = 1'b0;
`ifdef AMBIENT_CANCEL_EN
    w_to_lit      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_clr = 1'b1;
`ifdef AMBIENT_CANCEL_EN
          // dark pass needs no emitter settle time
          w_next = S_START;
`else
          w_load_settle = 1'b1;
          w_next        = S_SETTLE;
`endif
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_next = S_START;
      end
      S_START: begin
        w_load_to = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the last timeout cycle still counts
        if (a2d.cnv_cmplt) begin
          w_store = 1'b1;
          if (r_ch == LAST_CH) begin
`ifdef AMBIENT_CANCEL_EN
            if (!r_lit) begin
              w_to_lit      = 1'b1;
              w_load_settle = 1'b1;
              w_next        = S_SETTLE;
            end else begin
              w_next = S_DONE;
            end
`else
            w_next = S_DONE;
`endif
          end else begin
            w_inc  = 1'b1;
            w_next = S_START;
          end
        end else if (r_cnt == '0) begin
          w_err_set = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared settle/timeout down-counter, channel counter, error flag.
  // Loading N-1 gives exactly N cycles in SETTLE (or N cycles of WAIT before timeout).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ch  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_load_settle)      r_cnt <= CW'(SETTLE_CYCLES - 1);
      else if (w_load_to)     r_cnt <= CW'(TIMEOUT_CYCLES - 1);
      else if (r_cnt != '0)   r_cnt <= r_cnt - CW'(1);

      if (w_clr)              r_ch <= '0;
`ifdef AMBIENT_CANCEL_EN
      else if (w_to_lit)      r_ch <= '0;
`endif
      else if (w_inc)         r_ch <= r_ch + 3'd1;

      if (w_clr)              r_err <= 1'b0;
      else if (w_err_set)     r_err <= 1'b1;
    end
  end

`ifdef AMBIENT_CANCEL_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lit <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_amb[i] <= '0;
    end else begin
      if (w_clr)         r_lit <= 1'b0;
      else if (w_to_lit) r_lit <= 1'b1;
      if (w_store && !r_lit) begin
        for (int i = 0; i < NUM_CH; i++)
          if (r_ch == 3'(i)) r_amb[i] <= a2d.res;
      end
    end
  end

  always_comb begin
    w_amb_cur = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_ch == 3'(i)) w_amb_cur = r_amb[i];
    w_wr_data = (a2d.res > w_amb_cur) ? (a2d.res - w_amb_cur) : 12'h000;
  end
`else
  always_comb begin
    w_wr_data = a2d.res;
  end
`endif

  // Lit-pass result bank
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_bank[i] <= '0;
    end else if (w_store && w_lit) begin
      for (int i = 0; i < NUM_CH; i++)
        if (r_ch == 3'(i)) r_bank[i] <= w_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (i_rd_idx == 3'(i)) o_rd_data = r_bank[i];
  end

  assign a2d.strt_cnv  = (r_state == S_START);
  assign a2d.chnnl     = r_ch;
  assign o_busy        = (r_state != S_IDLE);
  assign o_sweep_done  = (r_state == S_DONE);
  assign o_a2d_err     = r_err;
  assign o_ir_en       = w_lit && ((r_state == S_SETTLE) || (r_state == S_START) ||
                                   (r_state == S_WAIT));

endmodule

// File: doc/ir_sensor_sweep.md
Name: ir_sensor_sweep

Overview:
- Upstream sequencer for the A2D SPI interface on the line follower.
- On a `go` request it:
  - enables the IR emitters and waits a settle time;
  - converts sensor channels 0..NUM_CH-1 in order using the A2D strt_cnv/cnv_cmplt handshake;
  - stores each 12-bit result in a register bank readable by the steering/error logic.
- Pulses sweep_done when a full set of readings is valid.

Parameters:
- NUM_CH, 8, number of sensor channels swept (legal 1..8); channels 0..NUM_CH-1.
- SETTLE_CYCLES, 4096, clocks between ir_en rising and first strt_cnv (legal ≥1).
- TIMEOUT_CYCLES, 2047, max clocks to wait for cnv_cmplt before aborting the sweep (legal ≥1100).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- go  input  1  sweep request; sampled only in IDLE.
- strt_cnv  output  1  one-cycle conversion start to A2D.
- chnnl  output  3  channel for current conversion; stable from strt_cnv until cnv_cmplt.
- cnv_cmplt  input  1  A2D conversion complete (level; A2D clears it the cycle after strt_cnv).
- res  input  12  A2D result; valid while cnv_cmplt=1.
- ir_en  output  1  IR emitter enable.
- busy  output  1  high in any state other than IDLE.
- sweep_done  output  1  one-cycle pulse, all NUM_CH results updated.
- a2d_err  output  1  sticky timeout flag; cleared by the next accepted go.
- rd_idx  input  3  result bank read index.
- rd_data  output  12  combinational read of bank[rd_idx]; 0 if rd_idx ≥ NUM_CH.

Behaviour:
- Reset (rst_n=0 at posedge), including mid-sweep:
  - state=IDLE; strt_cnv=0; ir_en=0; busy=0; sweep_done=0; a2d_err=0; chnnl=0; all bank entries=0.
- States: IDLE, SETTLE, START, WAIT, DONE.
- IDLE:
  - go=1 → clear a2d_err, ch_cnt=0, load settle counter, ir_en=1, go to SETTLE.
  - go while busy is ignored (no queuing).
- SETTLE: count SETTLE_CYCLES clocks, then START.
- START: strt_cnv=1 for exactly one cycle, chnnl=ch_cnt; load timeout counter; go to WAIT.
- WAIT (the cycle after strt_cnv; cnv_cmplt already cleared by A2D):
  - cnv_cmplt=1 → bank[ch_cnt]<=res.
    - If ch_cnt==NUM_CH-1 → DONE.
    - Else ch_cnt++ and START the next cycle.
  - Timeout reached first → a2d_err=1; bank untouched for the remaining channels; go to DONE.
  - cnv_cmplt and timeout in the same cycle: the result wins (stored, no error).
- DONE: sweep_done=1 for one cycle; ir_en=0; go to IDLE. ir_en is 1 in SETTLE/START/WAIT only.
- Spacing: back-to-back conversions are separated by exactly one WAIT→START edge; no resettle between channels.
- ch_cnt is 3 bits; no wrap beyond NUM_CH-1.
- Latency: strt_cnv of ch0 occurs SETTLE_CYCLES+1 clocks after go is sampled.
- rd_data: reading an entry during its write cycle returns the old value (register read).

Optional Feature:
- Macro: AMBIENT_CANCEL_EN.
- Defined:
  - Sweep starts with an ambient pass, ir_en=0 and no settle: channels 0..NUM_CH-1 converted into a separate ambient bank.
  - Then ir_en=1, SETTLE, then the lit pass.
  - Stored lit value is lit-res minus ambient, saturated at 0 (12-bit unsigned; lit<ambient → 0).
  - A timeout in either pass aborts the whole sweep with a2d_err=1.
  - sweep_done pulses once, after the lit pass.
- Undefined: single lit pass only; no ambient bank is instantiated.

Test Plan:
- Reset then go pulse, A2D model returns res=0x100+ch after 1040 clks → strt_cnv first at go+SETTLE_CYCLES+1; chnnl steps 0..7; bank[i]=0x100+i; one sweep_done pulse; ir_en=0 after DONE.
- go re-asserted during WAIT of ch3 → ignored; exactly 8 strt_cnv pulses and a single sweep_done.
- A2D model never asserts cnv_cmplt for ch5 → after 2047 WAIT clks a2d_err=1, sweep_done pulses, bank[5..7] retain old values; next go clears a2d_err.
- rst_n=0 for one clock during SETTLE → next cycle all outputs 0, state IDLE, bank zeroed; a fresh go runs a full sweep.
- NUM_CH=3, rd_idx=6 → rd_data=0; only chnnl 0..2 issued.
- AMBIENT_CANCEL_EN, ambient=0x080 and lit=0x300 on ch0, ambient=0x200 and lit=0x150 on ch1 → bank[0]=0x280, bank[1]=0x000; 16 strt_cnv pulses; ir_en=0 during the first 8.
